// File: rtl/linebuff_kxk_win_if.sv
// Pixel-stream / window bus for linebuff_kxk_win.
// The slave modport is the line buffer; the master is the pixel source and window consumer.
interface linebuff_kxk_win_if #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_COLS   = 32,
    parameter int IMG_ROWS   = 32,
    parameter int KERNEL     = 5,
    parameter int NUM_CH     = 1
);
    logic                                                     lb_clr_i;
    logic                                                     lb_vld_i;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0]                        lb_data_i;
    logic [NUM_CH-1:0][KERNEL-1:0][KERNEL-1:0][DATA_WIDTH-1:0] lb_win_o;
    logic                                                     lb_win_vld_o;
    logic [$clog2(IMG_ROWS)-1:0]                              lb_row_o;
    logic [$clog2(IMG_COLS)-1:0]                              lb_col_o;
    logic                                                     lb_frame_done_o;

    modport slave (
        input  lb_clr_i, lb_vld_i, lb_data_i,
        output lb_win_o, lb_win_vld_o, lb_row_o, lb_col_o, lb_frame_done_o
    );

    modport master (
        output lb_clr_i, lb_vld_i, lb_data_i,
        input  lb_win_o, lb_win_vld_o, lb_row_o, lb_col_o, lb_frame_done_o
    );
endinterface

// File: rtl/linebuff_kxk_win.sv
// KERNEL x KERNEL sliding-window generator over a raster pixel stream, NUM_CH channels in lockstep.
// KERNEL-1 cascaded line buffers feed the right column of the window; stride validity uses phase counters.
module linebuff_kxk_win #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_COLS   = 32,
    parameter int IMG_ROWS   = 32,
    parameter int KERNEL     = 5,
    parameter int NUM_CH     = 1,
    parameter int STRIDE     = 1
) (
    input  logic              lb_clk,
    input  logic              lb_rst_b,
    linebuff_kxk_win_if.slave lb_if
);
    localparam int          RW    = $clog2(IMG_ROWS);
    localparam int          CW    = $clog2(IMG_COLS);
    localparam int          PW    = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int unsigned KM1   = KERNEL - 1;
    localparam int unsigned DEPTH = (KERNEL - 1) * IMG_COLS;

    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_COLS - 1);
    localparam logic [RW-1:0] ROW_K    = RW'(KERNEL - 1);
    localparam logic [CW-1:0] COL_K    = CW'(KERNEL - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(STRIDE - 1);

    typedef logic [NUM_CH-1:0][KERNEL-1:0][KERNEL-1:0][DATA_WIDTH-1:0] win_t;

    logic [DATA_WIDTH-1:0] lbuf_q [NUM_CH][DEPTH];
    win_t                  win_q, win_d;
    logic [RW-1:0]         row_q, row_d, row_o_q, row_o_d;
    logic [CW-1:0]         col_q, col_d, col_o_q, col_o_d;
    logic [PW-1:0]         rph_q, rph_d, cph_q, cph_d;
    logic                  win_vld_q, win_vld_d;
    logic                  done_q, done_d;
    logic                  accept;

    assign accept = lb_if.lb_vld_i & ~lb_if.lb_clr_i;

    function automatic logic [PW-1:0] next_phase(input logic [PW-1:0] p);
        return (p == PH_LAST) ? '0 : p + 1'b1;
    endfunction

    // Phase counters only advance once the position is inside the valid region,
    // so phase 0 there means (pos - (KERNEL-1)) % STRIDE == 0.
    always_comb begin
        row_d     = row_q;
        col_d     = col_q;
        rph_d     = rph_q;
        cph_d     = cph_q;
        row_o_d   = row_o_q;
        col_o_d   = col_o_q;
        win_vld_d = 1'b0;
        done_d    = 1'b0;
        if (lb_if.lb_clr_i) begin
            row_d   = '0;
            col_d   = '0;
            rph_d   = '0;
            cph_d   = '0;
            row_o_d = '0;
            col_o_d = '0;
        end else if (lb_if.lb_vld_i) begin
            row_o_d   = row_q;
            col_o_d   = col_q;
            win_vld_d = (row_q >= ROW_K) && (col_q >= COL_K) && (rph_q == '0) && (cph_q == '0);
            done_d    = (row_q == ROW_LAST) && (col_q == COL_LAST);
            if (col_q == COL_LAST) begin
                col_d = '0;
                cph_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d = '0;
                    rph_d = '0;
                end else begin
                    row_d = row_q + 1'b1;
                    rph_d = (row_q >= ROW_K) ? next_phase(rph_q) : '0;
                end
            end else begin
                col_d = col_q + 1'b1;
                cph_d = (col_q >= COL_K) ? next_phase(cph_q) : '0;
            end
        end
    end

    // Line l's tail holds the pixel (l+1) rows above the incoming one, same column.
    always_comb begin
        win_d = win_q;
        if (lb_if.lb_clr_i) begin
            win_d = '0;
        end else if (lb_if.lb_vld_i) begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                for (int unsigned i = 0; i < KERNEL; i++) begin
                    for (int unsigned j = 0; j < KM1; j++) begin
                        win_d[ch][i][j] = win_q[ch][i][j+1];
                    end
                end
                for (int unsigned i = 0; i < KM1; i++) begin
                    win_d[ch][i][KM1] = lbuf_q[ch][(KM1 - 1 - i) * IMG_COLS + IMG_COLS - 1];
                end
                win_d[ch][KM1][KM1] = lb_if.lb_data_i[ch];
            end
        end
    end

    always_ff @(posedge lb_clk or negedge lb_rst_b) begin
        if (!lb_rst_b) begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                for (int unsigned k = 0; k < DEPTH; k++) begin
                    lbuf_q[ch][k] <= '0;
                end
            end
        end else if (accept) begin
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                lbuf_q[ch][0] <= lb_if.lb_data_i[ch];
                for (int unsigned k = 1; k < DEPTH; k++) begin
                    lbuf_q[ch][k] <= lbuf_q[ch][k-1];
                end
            end
        end
    end

    always_ff @(posedge lb_clk or negedge lb_rst_b) begin
        if (!lb_rst_b) begin
            win_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            rph_q     <= '0;
            cph_q     <= '0;
            row_o_q   <= '0;
            col_o_q   <= '0;
            win_vld_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            win_q     <= win_d;
            row_q     <= row_d;
            col_q     <= col_d;
            rph_q     <= rph_d;
            cph_q     <= cph_d;
            row_o_q   <= row_o_d;
            col_o_q   <= col_o_d;
            win_vld_q <= win_vld_d;
            done_q    <= done_d;
        end
    end

    assign lb_if.lb_win_o        = win_q;
    assign lb_if.lb_win_vld_o    = win_vld_q;
    assign lb_if.lb_row_o        = row_o_q;
    assign lb_if.lb_col_o        = col_o_q;
    assign lb_if.lb_frame_done_o = done_q;

endmodule

// File: tb/tb_linebuff_kxk_win.sv
// Bench for linebuff_kxk_win: a 2-channel stride-1 instance and a 1-channel stride-2 instance
// share one 5x5 stream; expected windows are rebuilt from pixel coordinates.
`timescale 1ns/1ps
module tb_linebuff_kxk_win;
    localparam int DW   = 16;
    localparam int COLS = 5;
    localparam int ROWS = 5;
    localparam int K    = 3;

    typedef logic [1:0][K-1:0][K-1:0][DW-1:0] win2_t;
    typedef logic [0:0][K-1:0][K-1:0][DW-1:0] win1_t;
    typedef logic [2*K*K*DW-1:0]              wbits_t;

    typedef struct {
        bit acc;
        bit clr;
        bit va;
        bit vb;
        bit done;
        int row;
        int col;
        int base;
    } exp_t;

    typedef struct {
        string name;
        int    npix;
        int    gap_pct;
        int    base;
        bit    clr_first;
        int    exp_a;
        int    exp_b;
        int    exp_d;
    } vec_t;

    logic lb_clk = 1'b0;
    logic lb_rst_b = 1'b0;
    always #5 lb_clk = ~lb_clk;

    linebuff_kxk_win_if #(.DATA_WIDTH(DW), .IMG_COLS(COLS), .IMG_ROWS(ROWS), .KERNEL(K), .NUM_CH(2)) if_a ();
    linebuff_kxk_win_if #(.DATA_WIDTH(DW), .IMG_COLS(COLS), .IMG_ROWS(ROWS), .KERNEL(K), .NUM_CH(1)) if_b ();

    linebuff_kxk_win #(.DATA_WIDTH(DW), .IMG_COLS(COLS), .IMG_ROWS(ROWS), .KERNEL(K), .NUM_CH(2), .STRIDE(1)) dut_a (
        .lb_clk  (lb_clk),
        .lb_rst_b(lb_rst_b),
        .lb_if   (if_a)
    );

    linebuff_kxk_win #(.DATA_WIDTH(DW), .IMG_COLS(COLS), .IMG_ROWS(ROWS), .KERNEL(K), .NUM_CH(1), .STRIDE(2)) dut_b (
        .lb_clk  (lb_clk),
        .lb_rst_b(lb_rst_b),
        .lb_if   (if_b)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];
    int   m_row = 0, m_col = 0;
    bit   last_known = 1'b1;
    int   last_row = 0, last_col = 0;
    int   cnt_a, cnt_b, cnt_d;
    vec_t tbl[5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input wbits_t act, input wbits_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic win2_t exp_win(input int base, input int r, input int c);
        win2_t w;
        int    v;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                v = base + (r - (K - 1) + i) * COLS + (c - (K - 1) + j);
                w[0][i][j] = DW'(v);
                w[1][i][j] = DW'(v + 100);
            end
        end
        return w;
    endfunction

    task automatic check_out();
        exp_t  e;
        win2_t ea;
        win1_t eb;
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
            return;
        end
        e = sbq.pop_front();
        chk("vld_a", int'(if_a.lb_win_vld_o), int'(e.va));
        chk("vld_b", int'(if_b.lb_win_vld_o), int'(e.vb));
        chk("done_a", int'(if_a.lb_frame_done_o), int'(e.done));
        chk("done_b", int'(if_b.lb_frame_done_o), int'(e.done));
        cnt_a += int'(if_a.lb_win_vld_o);
        cnt_b += int'(if_b.lb_win_vld_o);
        cnt_d += int'(if_a.lb_frame_done_o);
        ea = exp_win(e.base, e.row, e.col);
        eb[0] = ea[0];
        if (e.va) begin
            chk("row_a", int'(if_a.lb_row_o), e.row);
            chk("col_a", int'(if_a.lb_col_o), e.col);
            chkw("win_a", wbits_t'(if_a.lb_win_o), wbits_t'(ea));
        end
        if (e.vb) begin
            chk("row_b", int'(if_b.lb_row_o), e.row);
            chk("col_b", int'(if_b.lb_col_o), e.col);
            chkw("win_b", {{(K*K*DW){1'b0}}, if_b.lb_win_o}, {{(K*K*DW){1'b0}}, eb});
        end
        if (e.clr) begin
            last_known = 1'b0;
        end else if (e.acc) begin
            last_known = 1'b1;
            last_row   = e.row;
            last_col   = e.col;
        end else if (last_known) begin
            chk("hold_row_a", int'(if_a.lb_row_o), last_row);
            chk("hold_col_a", int'(if_a.lb_col_o), last_col);
        end
    endtask

    // Drive one cycle's inputs, queue the expected result, then compare after the edge.
    task automatic cycle(input bit v, input bit clr, input int base);
        exp_t        e;
        logic [DW-1:0] px;
        bit          acc;
        acc = v && !clr;
        px  = v ? DW'(base + m_row * COLS + m_col) : DW'($urandom);
        if_a.lb_vld_i     = v;
        if_a.lb_clr_i     = clr;
        if_a.lb_data_i[0] = px;
        if_a.lb_data_i[1] = px + DW'(100);
        if_b.lb_vld_i     = v;
        if_b.lb_clr_i     = clr;
        if_b.lb_data_i[0] = px;
        e.acc  = acc;
        e.clr  = clr;
        e.row  = m_row;
        e.col  = m_col;
        e.base = base;
        e.va   = acc && (m_row >= K - 1) && (m_col >= K - 1);
        e.vb   = e.va && ((m_row - (K - 1)) % 2 == 0) && ((m_col - (K - 1)) % 2 == 0);
        e.done = acc && (m_row == ROWS - 1) && (m_col == COLS - 1);
        if (clr) begin
            m_row = 0;
            m_col = 0;
        end else if (acc) begin
            if (m_col == COLS - 1) begin
                m_col = 0;
                m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
            end else begin
                m_col = m_col + 1;
            end
        end
        sbq.push_back(e);
        @(posedge lb_clk);
        #1;
        check_out();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_vld_a"}, int'(if_a.lb_win_vld_o), 0);
        chk({tag, "_vld_b"}, int'(if_b.lb_win_vld_o), 0);
        chk({tag, "_done_a"}, int'(if_a.lb_frame_done_o), 0);
        chk({tag, "_row_a"}, int'(if_a.lb_row_o), 0);
        chk({tag, "_col_a"}, int'(if_a.lb_col_o), 0);
        chkw({tag, "_win_a"}, wbits_t'(if_a.lb_win_o), '0);
        chkw({tag, "_win_b"}, {{(K*K*DW){1'b0}}, if_b.lb_win_o}, '0);
    endtask

    task automatic stream(input int npix, input int gap_pct, input int base);
        int n = 0;
        int guard = 0;
        while (n < npix && guard < 1000) begin
            if ($urandom_range(0, 99) < gap_pct) begin
                cycle(1'b0, 1'b0, base);
            end else begin
                cycle(1'b1, 1'b0, base);
                n++;
            end
            guard++;
        end
        chk("stream_budget", n, npix);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{"basic",     25,  0,  0, 1'b0, 9, 4, 1};
        tbl[1] = '{"gap_f1",    25, 50,  0, 1'b0, 9, 4, 1};
        tbl[2] = '{"gap_f2",    25, 50,  0, 1'b0, 9, 4, 1};
        tbl[3] = '{"abort_pre",  8,  0,  0, 1'b0, 0, 0, 0};
        tbl[4] = '{"abort_new", 25,  0, 50, 1'b1, 9, 4, 1};

        if_a.lb_vld_i = 1'b0; if_a.lb_clr_i = 1'b0; if_a.lb_data_i = '0;
        if_b.lb_vld_i = 1'b0; if_b.lb_clr_i = 1'b0; if_b.lb_data_i = '0;
        #12;
        check_all_zero("reset");
        @(posedge lb_clk);
        #1;
        lb_rst_b = 1'b1;

        for (int k = 0; k < 5; k++) begin
            cnt_a = 0; cnt_b = 0; cnt_d = 0;
            if (tbl[k].clr_first) cycle(1'b1, 1'b1, 0);
            stream(tbl[k].npix, tbl[k].gap_pct, tbl[k].base);
            chk($sformatf("%s_cnt_a", tbl[k].name), cnt_a, tbl[k].exp_a);
            chk($sformatf("%s_cnt_b", tbl[k].name), cnt_b, tbl[k].exp_b);
            chk($sformatf("%s_cnt_done", tbl[k].name), cnt_d, tbl[k].exp_d);
        end

        // Asynchronous reset partway through row 3, away from any clock edge.
        stream(17, 0, 0);
        #3;
        if_a.lb_vld_i = 1'b0;
        if_b.lb_vld_i = 1'b0;
        lb_rst_b = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge lb_clk);
        #1;
        lb_rst_b   = 1'b1;
        m_row      = 0;
        m_col      = 0;
        last_known = 1'b1;
        last_row   = 0;
        last_col   = 0;
        cnt_a = 0; cnt_b = 0; cnt_d = 0;
        cycle(1'b0, 1'b0, 0);
        stream(25, 0, 0);
        chk("post_rst_cnt_a", cnt_a, 9);
        chk("post_rst_cnt_b", cnt_b, 4);
        chk("post_rst_cnt_done", cnt_d, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
